// File: rtl/pixel_window_pkg.sv
// Shared constants, tap numbering and scan FSM encoding for the 3x3 window generator.
package pixel_window_pkg;

  localparam int unsigned SIDE_BITS = 8;
  localparam int unsigned PIX_W     = 4;
  localparam int unsigned ADDR_W    = 2 * SIDE_BITS;
  localparam int unsigned WIN_W     = 9 * PIX_W;

  localparam int unsigned TAP_UL = 0;
  localparam int unsigned TAP_UC = 1;
  localparam int unsigned TAP_UR = 2;
  localparam int unsigned TAP_L  = 3;
  localparam int unsigned TAP_C  = 4;
  localparam int unsigned TAP_R  = 5;
  localparam int unsigned TAP_LL = 6;
  localparam int unsigned TAP_LC = 7;
  localparam int unsigned TAP_LR = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_e;

endpackage

// File: rtl/window_line_buf.sv
// Two chained one-row delay lines; outputs the samples one and two rows behind the input.
module window_line_buf #(
  parameter int unsigned DEPTH_BITS = 8,
  parameter int unsigned DATA_W     = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_pix,
  output logic [DATA_W-1:0] o_row1,
  output logic [DATA_W-1:0] o_row2
);
  import pixel_window_pkg::*;

  localparam logic [DEPTH_BITS-1:0] PTR_ONE = 1;

  logic [DATA_W-1:0]     line1_q [2**DEPTH_BITS];
  logic [DATA_W-1:0]     line2_q [2**DEPTH_BITS];
  logic [DEPTH_BITS-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (i_en) ptr_d = ptr_q + PTR_ONE;
  end

  // Read-before-write at the shared pointer gives an exact one-row delay per stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) ptr_q <= '0;
    else       ptr_q <= ptr_d;
    if (i_en) begin
      line1_q[ptr_q] <= i_pix;
      line2_q[ptr_q] <= line1_q[ptr_q];
    end
  end

  assign o_row1 = line1_q[ptr_q];
  assign o_row2 = line2_q[ptr_q];

endmodule

// File: rtl/pixel_window_gen.sv
// Scans the image RAM once per frame and streams zero-padded 3x3 windows with their centre address.
module pixel_window_gen #(
  parameter int unsigned SIDE_BITS = pixel_window_pkg::SIDE_BITS,
  parameter int unsigned PIX_W     = pixel_window_pkg::PIX_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_rdEn,
  output logic [2*SIDE_BITS-1:0] o_rdAddr,
  input  logic [PIX_W-1:0]       i_rdData,
  output logic [9*PIX_W-1:0]     o_win,
  output logic [2*SIDE_BITS-1:0] o_winIdx,
  output logic                   o_winValid,
  input  logic                   i_winReady
);
  import pixel_window_pkg::*;

  localparam int unsigned AW = 2 * SIDE_BITS;
  localparam int unsigned WW = 9 * PIX_W;
  localparam logic [AW-1:0]      ADDR_ONE  = 1;
  localparam logic [AW-1:0]      FILL_LAST = AW'(1 << SIDE_BITS);
  localparam logic [SIDE_BITS:0] CNT_ONE   = 1;
  localparam logic [SIDE_BITS:0] LAG_CNT   = (SIDE_BITS + 1)'((1 << SIDE_BITS) + 1);

  state_e               state_q, state_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [AW-1:0]        rd_addr_q, rd_addr_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [PIX_W-1:0]     skid_q, skid_d;
  logic [SIDE_BITS:0]   flush_cnt_q, flush_cnt_d;
  logic [SIDE_BITS:0]   prime_cnt_q, prime_cnt_d;
  logic [AW-1:0]        cen_q, cen_d;
  logic [PIX_W-1:0]     top_c_q, top_c_d, top_r_q, top_r_d;
  logic [PIX_W-1:0]     mid_c_q, mid_c_d, mid_r_q, mid_r_d;
  logic [PIX_W-1:0]     bot_c_q, bot_c_d, bot_r_q, bot_r_d;
  logic [WW-1:0]        win_q, win_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic                 win_valid_q, win_valid_d;

  logic                 adv, rd_issue, have_ram, zero_step, shift, primed;
  logic [PIX_W-1:0]     shift_pix, lb_row1, lb_row2;
  logic [PIX_W-1:0]     tap [9];
  logic [WW-1:0]        win_pad;
  logic [SIDE_BITS-1:0] cen_row, cen_col;

  assign adv       = !win_valid_q || i_winReady;
  // Read strobe follows adv combinationally so at most one read is ever in flight during a stall.
  assign rd_issue  = ((state_q == ST_FILL) || (state_q == ST_RUN)) && adv;
  assign have_ram  = skid_valid_q || rd_pend_q;
  assign zero_step = (state_q == ST_FLUSH) && !have_ram && (flush_cnt_q != LAG_CNT);
  assign shift     = adv && (have_ram || zero_step);
  assign shift_pix = skid_valid_q ? skid_q : (rd_pend_q ? i_rdData : '0);
  assign primed    = (prime_cnt_q == LAG_CNT);
  assign cen_row   = cen_q[AW-1:SIDE_BITS];
  assign cen_col   = cen_q[SIDE_BITS-1:0];

  window_line_buf #(
    .DEPTH_BITS (SIDE_BITS),
    .DATA_W     (PIX_W)
  ) u_line_buf (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (shift),
    .i_pix  (shift_pix),
    .o_row1 (lb_row1),
    .o_row2 (lb_row2)
  );

  // Window is built from the post-shift taps so it registers on the same edge as the shift.
  always_comb begin
    tap[TAP_UL] = top_c_q;  tap[TAP_UC] = top_r_q;  tap[TAP_UR] = lb_row2;
    tap[TAP_L]  = mid_c_q;  tap[TAP_C]  = mid_r_q;  tap[TAP_R]  = lb_row1;
    tap[TAP_LL] = bot_c_q;  tap[TAP_LC] = bot_r_q;  tap[TAP_LR] = shift_pix;
    if (cen_col == '0) begin tap[TAP_UL] = '0; tap[TAP_L] = '0; tap[TAP_LL] = '0; end
    if (cen_col == '1) begin tap[TAP_UR] = '0; tap[TAP_R] = '0; tap[TAP_LR] = '0; end
    if (cen_row == '0) begin tap[TAP_UL] = '0; tap[TAP_UC] = '0; tap[TAP_UR] = '0; end
    if (cen_row == '1) begin tap[TAP_LL] = '0; tap[TAP_LC] = '0; tap[TAP_LR] = '0; end
    win_pad = '0;
    for (int unsigned k = 0; k < 9; k++) win_pad[k*PIX_W +: PIX_W] = tap[k];
  end

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_pend_d    = rd_issue;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    flush_cnt_d  = flush_cnt_q;
    prime_cnt_d  = prime_cnt_q;
    cen_d        = cen_q;
    top_c_d = top_c_q;  top_r_d = top_r_q;
    mid_c_d = mid_c_q;  mid_r_d = mid_r_q;
    bot_c_d = bot_c_q;  bot_r_d = bot_r_q;
    win_d        = win_q;
    idx_d        = idx_q;
    win_valid_d  = win_valid_q;

    if (skid_valid_q) begin
      if (adv) skid_valid_d = 1'b0;
    end else if (rd_pend_q && !adv) begin
      skid_valid_d = 1'b1;
      skid_d       = i_rdData;
    end

    if (rd_issue && (rd_addr_q != '1)) rd_addr_d = rd_addr_q + ADDR_ONE;
    if (zero_step && adv) flush_cnt_d = flush_cnt_q + CNT_ONE;

    if (shift) begin
      top_c_d = top_r_q;  top_r_d = lb_row2;
      mid_c_d = mid_r_q;  mid_r_d = lb_row1;
      bot_c_d = bot_r_q;  bot_r_d = shift_pix;
      if (!primed) begin
        prime_cnt_d = prime_cnt_q + CNT_ONE;
      end else begin
        win_d       = win_pad;
        idx_d       = cen_q;
        win_valid_d = 1'b1;
        if (cen_q != '1) cen_d = cen_q + ADDR_ONE;
      end
    end else if (adv) begin
      win_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d     = ST_FILL;
          busy_d      = 1'b1;
          rd_addr_d   = '0;
          cen_d       = '0;
          prime_cnt_d = '0;
          flush_cnt_d = '0;
        end
      end
      ST_FILL:  if (rd_issue && (rd_addr_q == FILL_LAST)) state_d = ST_RUN;
      ST_RUN:   if (rd_issue && (rd_addr_q == '1)) state_d = ST_FLUSH;
      ST_FLUSH: begin
        if ((flush_cnt_q == LAG_CNT) && !have_ram && adv) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_addr_q    <= '0;
      rd_pend_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      flush_cnt_q  <= '0;
      prime_cnt_q  <= '0;
      cen_q        <= '0;
      top_c_q <= '0;  top_r_q <= '0;
      mid_c_q <= '0;  mid_r_q <= '0;
      bot_c_q <= '0;  bot_r_q <= '0;
      win_q        <= '0;
      idx_q        <= '0;
      win_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_addr_q    <= rd_addr_d;
      rd_pend_q    <= rd_pend_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      flush_cnt_q  <= flush_cnt_d;
      prime_cnt_q  <= prime_cnt_d;
      cen_q        <= cen_d;
      top_c_q <= top_c_d;  top_r_q <= top_r_d;
      mid_c_q <= mid_c_d;  mid_r_q <= mid_r_d;
      bot_c_q <= bot_c_d;  bot_r_q <= bot_r_d;
      win_q        <= win_d;
      idx_q        <= idx_d;
      win_valid_q  <= win_valid_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_rdEn     = rd_issue;
  assign o_rdAddr   = rd_addr_q;
  assign o_win      = win_q;
  assign o_winIdx   = idx_q;
  assign o_winValid = win_valid_q;

endmodule

// File: tb/tb_pixel_window_gen.sv
// Frame-level checks of pixel_window_gen against a direct neighbourhood model of the image.
module tb_pixel_window_gen;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_ready;
  logic        o_busy, o_done, o_rdEn, o_winValid;
  logic [15:0] o_rdAddr, o_winIdx;
  logic [3:0]  rd_data;
  logic [35:0] o_win;

  logic [3:0]  mem [65536];

  int n_checks = 0;
  int n_errors = 0;

  int accepted, rd_cnt, stalls, busy_cnt, done_cnt;
  int first_valid, first_rd, done_cyc, last_acc_cyc, cyc;
  bit timed_out;

  pixel_window_gen dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_rdEn     (o_rdEn),
    .o_rdAddr   (o_rdAddr),
    .i_rdData   (rd_data),
    .o_win      (o_win),
    .o_winIdx   (o_winIdx),
    .o_winValid (o_winValid),
    .i_winReady (i_ready)
  );

  always #5 clk = ~clk;

  // Single-port image RAM, one cycle read latency.
  always @(posedge clk) if (o_rdEn) rd_data <= mem[o_rdAddr];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] golden(input int idx);
    logic [35:0] w;
    int r, c, rr, cc;
    w = '0;
    r = idx / 256;
    c = idx % 256;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if (rr >= 0 && rr < 256 && cc >= 0 && cc < 256)
          w[((dr + 1) * 3 + (dc + 1)) * 4 +: 4] = mem[rr * 256 + cc];
      end
    return w;
  endfunction

  function automatic logic [51:0] outs_all();
    return {o_busy, o_done, o_rdEn, o_winValid, o_rdAddr, o_winIdx, o_win[15:0]} |
           {32'd0, o_win[35:16]};
  endfunction

  task automatic run_frame(input int abort_after, input int rand_from,
                           input int start_pulse_cyc, input bit const_img);
    logic [52:0] held;
    bit hold_pending;
    accepted = 0; rd_cnt = 0; stalls = 0; busy_cnt = 0; done_cnt = 0;
    first_valid = -1; first_rd = -1; done_cyc = -1; last_acc_cyc = -1;
    timed_out = 1'b1; hold_pending = 1'b0; held = '0;
    @(negedge clk);
    i_start = 1'b1;
    i_ready = 1'b1;
    cyc = 0;
    while (cyc < 75000) begin
      @(negedge clk);
      cyc++;
      i_start = (cyc == start_pulse_cyc);
      i_ready = (accepted >= rand_from) ? ($urandom_range(0, 1) == 1) : 1'b1;
      #1;
      if (o_busy) busy_cnt++;
      if (o_rdEn) begin
        if (first_rd < 0) first_rd = cyc;
        check_eq("rd_addr", o_rdAddr, rd_cnt[15:0]);
        rd_cnt++;
      end
      if (hold_pending) check_eq("stall_hold", {o_winValid, o_winIdx, o_win}, held);
      hold_pending = o_winValid && !i_ready;
      held = {o_winValid, o_winIdx, o_win};
      if (o_winValid) begin
        if (first_valid < 0) first_valid = cyc;
        if (i_ready) begin
          check_eq("window", {o_winIdx, o_win}, {accepted[15:0], golden(accepted)});
          if (const_img && accepted == 16'h0000) check_eq("const_idx0000", o_win, 36'hFF0FF0000);
          if (const_img && accepted == 16'h00FF) check_eq("const_idx00ff", o_win, 36'h0FF0FF000);
          if (const_img && accepted == 16'h0180) check_eq("const_interior", o_win, 36'hFFFFFFFFF);
          accepted++;
          last_acc_cyc = cyc;
        end else begin
          stalls++;
        end
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        timed_out = 1'b0;
        break;
      end
      if (accepted >= abort_after) begin
        timed_out = 1'b0;
        break;
      end
    end
    i_start = 1'b0;
    check_eq("frame_bound", timed_out, 1'b0);
  endtask

  initial begin
    int idle_bad;
    i_rst = 1'b1; i_start = 1'b0; i_ready = 1'b1;
    for (int a = 0; a < 65536; a++) mem[a] = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_outputs", outs_all(), '0);
    i_rst = 1'b0;

    // Constant image, random ready, abandoned by reset after 1000 windows.
    run_frame(1000, 0, 700, 1'b1);
    check_eq("abort_accepted", accepted, 1000);
    check_eq("abort_no_done", done_cnt, 0);
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    #1;
    check_eq("midframe_reset_outputs", outs_all(), '0);
    i_start = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    i_start = 1'b0;
    idle_bad = 0;
    repeat (300) begin
      @(negedge clk);
      #1;
      if (o_busy || o_done || o_rdEn || o_winValid) idle_bad++;
    end
    check_eq("idle_after_reset_start", idle_bad, 0);

    // Ramp image, ready high except for a random tail near end of frame.
    for (int a = 0; a < 65536; a++) begin
      logic [15:0] av;
      av = a[15:0];
      mem[a] = av[3:0] ^ av[11:8];
    end
    run_frame(65537, 65000, 30000, 1'b0);
    check_eq("n_windows", accepted, 65536);
    check_eq("n_reads", rd_cnt, 65536);
    check_eq("first_rd_cycle", first_rd, 1);
    check_eq("first_valid_cycle", first_valid, 260);
    check_eq("done_cycle", done_cyc, 65796 + stalls);
    check_eq("done_after_last_accept", done_cyc, last_acc_cyc + 1);
    check_eq("busy_cycles", busy_cnt, done_cyc);
    idle_bad = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (o_done || o_busy || o_rdEn || o_winValid) idle_bad++;
    end
    check_eq("idle_after_done", idle_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
